// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution unit: evaluates the condition, computes the actual next PC,
// flags mispredictions and holds one result for the CDB while keeping saturating counters.

module cmp (
  input  logic        valid,
  input  logic [2:0]  cmpop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        br_en
);

  // Undefined funct3 encodings never produce a taken condition
  always_comb begin
    br_en = 1'b0;
    if (valid) begin
      case (cmpop)
        3'b000:  br_en = (a == b);
        3'b001:  br_en = (a != b);
        3'b100:  br_en = ($signed(a) <  $signed(b));
        3'b101:  br_en = ($signed(a) >= $signed(b));
        3'b110:  br_en = (a <  b);
        3'b111:  br_en = (a >= b);
        default: br_en = 1'b0;
      endcase
    end
  end

endmodule

module branch_resolve_unit #(
  parameter int ROB_IDX_W = 5,
  parameter int PHYS_W    = 6,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic [1:0]           iss_kind,
  input  logic [2:0]           iss_cmpop,
  input  logic [31:0]          iss_rs1_v,
  input  logic [31:0]          iss_rs2_v,
  input  logic [31:0]          iss_pc,
  input  logic [31:0]          iss_imm,
  input  logic [31:0]          iss_pred_npc,
  input  logic [ROB_IDX_W-1:0] iss_rob_idx,
  input  logic [PHYS_W-1:0]    iss_pd,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ROB_IDX_W-1:0] res_rob_idx,
  output logic [PHYS_W-1:0]    res_pd,
  output logic [31:0]          res_data,
  output logic                 res_taken,
  output logic [31:0]          res_npc,
  output logic                 res_mispredict,
  output logic [CNT_W-1:0]     cnt_resolved,
  output logic [CNT_W-1:0]     cnt_mispredict
);

  localparam logic [1:0] KIND_BR   = 2'b00;
  localparam logic [1:0] KIND_JAL  = 2'b01;
  localparam logic [1:0] KIND_JALR = 2'b10;

  logic        is_branch;
  logic        br_en;
  logic        accept;
  logic        handshake;
  logic [31:0] link_pc;
  logic [31:0] target_pc;
  logic [31:0] jalr_pc;
  logic        calc_taken;
  logic [31:0] calc_npc;
  logic [31:0] calc_data;
  logic        calc_mispredict;

  assign is_branch = (iss_kind == KIND_BR);

  cmp u_cmp (
    .valid (is_branch),
    .cmpop (iss_cmpop),
    .a     (iss_rs1_v),
    .b     (iss_rs2_v),
    .br_en (br_en)
  );

  assign iss_ready = !res_valid || res_ready;
  assign accept    = iss_valid && iss_ready && !flush;
  assign handshake = res_valid && res_ready;

  assign link_pc   = iss_pc + 32'd4;
  assign target_pc = iss_pc + iss_imm;
  assign jalr_pc   = (iss_rs1_v + iss_imm) & ~32'd1;

  // Reserved kind falls into the branch arm; br_en is already 0 for it
  always_comb begin
    calc_taken = br_en;
    calc_npc   = br_en ? target_pc : link_pc;
    calc_data  = 32'd0;
    case (iss_kind)
      KIND_JAL: begin
        calc_taken = 1'b1;
        calc_npc   = target_pc;
        calc_data  = link_pc;
      end
      KIND_JALR: begin
        calc_taken = 1'b1;
        calc_npc   = jalr_pc;
        calc_data  = link_pc;
      end
      default: ;
    endcase
    calc_mispredict = (calc_npc != iss_pred_npc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid      <= 1'b0;
      res_rob_idx    <= '0;
      res_pd         <= '0;
      res_data       <= '0;
      res_taken      <= 1'b0;
      res_npc        <= '0;
      res_mispredict <= 1'b0;
    end else if (accept) begin
      res_valid      <= 1'b1;
      res_rob_idx    <= iss_rob_idx;
      res_pd         <= iss_pd;
      res_data       <= calc_data;
      res_taken      <= calc_taken;
      res_npc        <= calc_npc;
      res_mispredict <= calc_mispredict;
    end else if (flush || handshake) begin
      res_valid <= 1'b0;
    end
  end

  // A flushed result is discarded even if the CDB grants it in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_resolved   <= '0;
      cnt_mispredict <= '0;
    end else if (handshake && !flush) begin
      if (cnt_resolved != {CNT_W{1'b1}})
        cnt_resolved <= cnt_resolved + 1'b1;
      if (res_mispredict && (cnt_mispredict != {CNT_W{1'b1}}))
        cnt_mispredict <= cnt_mispredict + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed ops push hand-computed results,
// a negedge monitor pops and compares whenever the CDB consumes or a flush kills a result.

module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        iss_valid;
  logic        iss_ready;
  logic [1:0]  iss_kind;
  logic [2:0]  iss_cmpop;
  logic [31:0] iss_rs1_v;
  logic [31:0] iss_rs2_v;
  logic [31:0] iss_pc;
  logic [31:0] iss_imm;
  logic [31:0] iss_pred_npc;
  logic [4:0]  iss_rob_idx;
  logic [5:0]  iss_pd;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_rob_idx;
  logic [5:0]  res_pd;
  logic [31:0] res_data;
  logic        res_taken;
  logic [31:0] res_npc;
  logic        res_mispredict;
  logic [31:0] cnt_resolved;
  logic [31:0] cnt_mispredict;

  typedef struct {
    logic [4:0]  rob;
    logic [5:0]  pd;
    logic [31:0] data;
    logic        taken;
    logic [31:0] npc;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  branch_resolve_unit #(.ROB_IDX_W(5), .PHYS_W(6), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .iss_valid      (iss_valid),
    .iss_ready      (iss_ready),
    .iss_kind       (iss_kind),
    .iss_cmpop      (iss_cmpop),
    .iss_rs1_v      (iss_rs1_v),
    .iss_rs2_v      (iss_rs2_v),
    .iss_pc         (iss_pc),
    .iss_imm        (iss_imm),
    .iss_pred_npc   (iss_pred_npc),
    .iss_rob_idx    (iss_rob_idx),
    .iss_pd         (iss_pd),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_rob_idx    (res_rob_idx),
    .res_pd         (res_pd),
    .res_data       (res_data),
    .res_taken      (res_taken),
    .res_npc        (res_npc),
    .res_mispredict (res_mispredict),
    .cnt_resolved   (cnt_resolved),
    .cnt_mispredict (cnt_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveOp(input logic [1:0] kind, input logic [2:0] cmpop,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] pred, input logic [4:0] rob, input logic [5:0] pd);
    iss_valid    = 1'b1;
    iss_kind     = kind;
    iss_cmpop    = cmpop;
    iss_rs1_v    = rs1;
    iss_rs2_v    = rs2;
    iss_pc       = pc;
    iss_imm      = imm;
    iss_pred_npc = pred;
    iss_rob_idx  = rob;
    iss_pd       = pd;
  endtask

  task automatic pushExp(input logic [4:0] rob, input logic [5:0] pd, input logic [31:0] data,
                         input logic taken, input logic [31:0] npc, input logic mis);
    exp_t e;
    e.rob = rob; e.pd = pd; e.data = data; e.taken = taken; e.npc = npc; e.mis = mis;
    sb.push_back(e);
  endtask

  // One op offered for one cycle; its expected result is queued because it will be accepted
  task automatic applyStimulus(input logic [1:0] kind, input logic [2:0] cmpop,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] pred, input logic [4:0] rob, input logic [5:0] pd,
                               input logic [31:0] e_data, input logic e_taken,
                               input logic [31:0] e_npc, input logic e_mis);
    driveOp(kind, cmpop, rs1, rs2, pc, imm, pred, rob, pd);
    pushExp(rob, pd, e_data, e_taken, e_npc, e_mis);
    @(posedge clk); #1;
  endtask

  task automatic idleCycles(input int n);
    iss_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sb.delete();
    rst_n = 1'b1;
  endtask

  // Monitor: a flush kills the held result, otherwise a CDB grant consumes it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid) begin
        if (flush) begin
          if (sb.size() > 0) void'(sb.pop_front());
        end else if (res_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_result_tag", {27'd0, res_rob_idx}, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            checkOutput("res_rob_idx", {27'd0, res_rob_idx}, {27'd0, e.rob});
            checkOutput("res_pd", {26'd0, res_pd}, {26'd0, e.pd});
            checkOutput("res_data", res_data, e.data);
            checkOutput("res_taken", {31'd0, res_taken}, {31'd0, e.taken});
            checkOutput("res_npc", res_npc, e.npc);
            checkOutput("res_mispredict", {31'd0, res_mispredict}, {31'd0, e.mis});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; res_ready = 1'b0;
    iss_valid = 1'b0; iss_kind = 2'b00; iss_cmpop = 3'b000;
    iss_rs1_v = '0; iss_rs2_v = '0; iss_pc = '0; iss_imm = '0;
    iss_pred_npc = '0; iss_rob_idx = '0; iss_pd = '0;
    doReset();

    $display("[TB] reset state");
    checkOutput("reset_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("reset_iss_ready", {31'd0, iss_ready}, 32'd1);
    checkOutput("reset_res_npc", res_npc, 32'd0);
    checkOutput("reset_res_data", res_data, 32'd0);
    checkOutput("reset_cnt_resolved", cnt_resolved, 32'd0);
    checkOutput("reset_cnt_mispredict", cnt_mispredict, 32'd0);

    $display("[TB] beq taken, mispredicted");
    res_ready = 1'b1;
    applyStimulus(2'b00, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 32'h104, 5'd1, 6'd3,
                  32'd0, 1'b1, 32'h120, 1'b1);
    checkOutput("beq_res_valid", {31'd0, res_valid}, 32'd1);
    idleCycles(1);
    checkOutput("beq_cnt_resolved", cnt_resolved, 32'd1);
    checkOutput("beq_cnt_mispredict", cnt_mispredict, 32'd1);

    $display("[TB] condition and next-PC stream");
    applyStimulus(2'b00, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 32'h210, 5'd2, 6'd0,
                  32'd0, 1'b1, 32'h210, 1'b0);
    applyStimulus(2'b00, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, 32'h310, 5'd3, 6'd0,
                  32'd0, 1'b0, 32'h304, 1'b1);
    applyStimulus(2'b00, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h600, 32'h8, 32'h604, 5'd4, 6'd0,
                  32'd0, 1'b0, 32'h604, 1'b0);
    applyStimulus(2'b00, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h700, 32'h8, 32'h704, 5'd5, 6'd0,
                  32'd0, 1'b1, 32'h708, 1'b1);
    applyStimulus(2'b00, 3'b010, 32'd9, 32'd9, 32'h800, 32'h40, 32'h840, 5'd6, 6'd0,
                  32'd0, 1'b0, 32'h804, 1'b1);
    applyStimulus(2'b11, 3'b000, 32'd9, 32'd9, 32'h900, 32'h40, 32'h904, 5'd8, 6'd1,
                  32'd0, 1'b0, 32'h904, 1'b0);
    applyStimulus(2'b01, 3'b000, 32'd0, 32'd0, 32'h500, 32'hFFFF_FFF0, 32'h4F0, 5'd9, 6'd2,
                  32'h504, 1'b1, 32'h4F0, 1'b0);
    applyStimulus(2'b10, 3'b000, 32'h2001, 32'd0, 32'h40, 32'h4, 32'h2004, 5'd7, 6'h2A,
                  32'h44, 1'b1, 32'h2004, 1'b0);
    idleCycles(1);
    checkOutput("stream_cnt_resolved", cnt_resolved, 32'd9);
    checkOutput("stream_cnt_mispredict", cnt_mispredict, 32'd4);

    $display("[TB] stall then same-cycle swap");
    res_ready = 1'b0;
    applyStimulus(2'b00, 3'b001, 32'd1, 32'd2, 32'hA00, 32'h20, 32'hA20, 5'd10, 6'd5,
                  32'd0, 1'b1, 32'hA20, 1'b0);
    driveOp(2'b00, 3'b000, 32'd1, 32'd2, 32'hB00, 32'h20, 32'hB04, 5'd11, 6'd6);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_iss_ready", {31'd0, iss_ready}, 32'd0);
      checkOutput("stall_res_valid", {31'd0, res_valid}, 32'd1);
      checkOutput("stall_res_rob_idx", {27'd0, res_rob_idx}, 32'd10);
      checkOutput("stall_res_npc", res_npc, 32'hA20);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    pushExp(5'd11, 6'd6, 32'd0, 1'b0, 32'hB04, 1'b0);
    @(posedge clk); #1;
    checkOutput("swap_res_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("swap_res_rob_idx", {27'd0, res_rob_idx}, 32'd11);
    idleCycles(1);
    checkOutput("swap_cnt_resolved", cnt_resolved, 32'd11);

    $display("[TB] flush kills held result and offered op");
    res_ready = 1'b0;
    applyStimulus(2'b01, 3'b000, 32'd0, 32'd0, 32'hC00, 32'h100, 32'd0, 5'd12, 6'd7,
                  32'hC04, 1'b1, 32'hD00, 1'b1);
    driveOp(2'b01, 3'b000, 32'd0, 32'd0, 32'hD00, 32'h100, 32'd0, 5'd13, 6'd8);
    flush = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    iss_valid = 1'b0;
    checkOutput("flush_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("flush_cnt_resolved", cnt_resolved, 32'd11);
    checkOutput("flush_cnt_mispredict", cnt_mispredict, 32'd4);
    idleCycles(1);
    checkOutput("flush_no_accept", {31'd0, res_valid}, 32'd0);

    $display("[TB] back-to-back stream after reset");
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b01, 3'b000, 32'd0, 32'd0, 32'h1000 + 32'(i * 16), 32'h8,
                    32'h1008 + 32'(i * 16), 5'(16 + i), 6'(20 + i),
                    32'h1004 + 32'(i * 16), 1'b1, 32'h1008 + 32'(i * 16), 1'b0);
    end
    idleCycles(1);
    checkOutput("b2b_cnt_resolved", cnt_resolved, 32'd4);
    checkOutput("b2b_cnt_mispredict", cnt_mispredict, 32'd0);

    $display("[TB] async reset mid-stream");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(2'b00, 3'b000, 32'd3, 32'd3, 32'h2000 + 32'(i * 16), 32'h40,
                    32'h2004 + 32'(i * 16), 5'(24 + i), 6'd0,
                    32'd0, 1'b1, 32'h2040 + 32'(i * 16), 1'b1);
    end
    #2;
    rst_n = 1'b0;
    iss_valid = 1'b0;
    #1;
    checkOutput("async_rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("async_rst_cnt_resolved", cnt_resolved, 32'd0);
    checkOutput("async_rst_cnt_mispredict", cnt_mispredict, 32'd0);
    @(posedge clk); #1;
    sb.delete();
    rst_n = 1'b1;
    checkOutput("post_rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    idleCycles(2);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
